// File: rtl/adder_share_pkg.sv
// Shared types and defaults for the shared-adder controller.
// Holds the controller state enum and default sizing constants.
package adder_share_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit from ptr up, wrapping.
// Ports: req, ptr in; grant (one-hot), grant_idx, any_req out.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = |req;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// One registered adder shared by NUM_REQ requesters via round-robin grant.
// Ports: clk, rst_n, req_* in / req_ready out, rsp_* valid-ready out, busy.
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int WIDTH   = DEF_WIDTH,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy
);

  state_t            state;
  state_t            state_nx;
  logic [ID_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   g_idx;
  logic              any_req;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic              op_cin;
  logic [ID_W-1:0]   op_id;
  logic [WIDTH:0]    sum_full;
  logic              accept;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (g_idx),
    .any_req   (any_req)
  );

  assign accept = (state == IDLE) && any_req;
  assign busy   = (state != IDLE);

  // Gated by rst_n so no grant is advertised while reset is held.
  assign req_ready = grant & {NUM_REQ{(state == IDLE) && rst_n}};

  assign sum_full = {1'b0, op_a} + {1'b0, op_b}
                  + (WIDTH+1)'(op_cin);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req)   state_nx = CALC;
      CALC:                   state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
    end else begin
      if (accept) begin
        op_a   <= req_a[g_idx*WIDTH +: WIDTH];
        op_b   <= req_b[g_idx*WIDTH +: WIDTH];
        op_cin <= req_cin[g_idx];
        op_id  <= g_idx;
        rr_ptr <= (g_idx == ID_W'(NUM_REQ-1)) ? '0
                : g_idx + ID_W'(1);
      end
      if (state == CALC) begin
        rsp_sum   <= sum_full[WIDTH-1:0];
        rsp_cout  <= sum_full[WIDTH];
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
